// File: rtl/rr_grant_encoder_pkg.sv
// Shared constants, state encoding and index helpers
// for the round-robin grant encoder.
package rr_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } st_e;

  // Wrap from N_REQ-1 to 0 comes from IDX_W-bit overflow.
  function automatic logic [IDX_W-1:0] inc_idx(
    input logic [IDX_W-1:0] v
  );
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_grant_encoder_pick.sv
// Round-robin pick: rotate by ptr, find first set bit,
// then add ptr back to get the absolute index.
module rr_pick
  import rr_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign idx = w_off + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over 8 requests, registered index
// with valid/ready. Optional burst lock: RR_GRANT_LOCK_EN.
module rr_grant_encoder
  import rr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
`ifdef RR_GRANT_LOCK_EN
  input  logic             lock,
`endif
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  input  logic             grant_rdy,
  output logic [IDX_W-1:0] ptr
);

  st_e              r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;

  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic             w_hold;

  // Priority base: stored ptr when idle, slot after the
  // current grant when re-arbitrating on a transfer.
  always_comb begin
    w_base = r_ptr;
    if (r_state == ST_GRANT) w_base = inc_idx(r_idx);
  end

  rr_pick u_pick (
    .req (req),
    .ptr (w_base),
    .idx (w_pick),
    .any (w_any)
  );

`ifdef RR_GRANT_LOCK_EN
  assign w_hold = lock & req[r_idx];
`else
  assign w_hold = 1'b0;
`endif

  // Grant FSM with registered index and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_idx   <= w_pick;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (grant_rdy && !w_hold) begin
            r_ptr <= inc_idx(r_idx);
            if (w_any) r_idx <= w_pick;
            else       r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_idx = r_idx;
  assign grant_vld = (r_state == ST_GRANT);
  assign ptr       = r_ptr;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder with a 3-to-8
// decoder model on grant_idx.
module tb_rr_grant_encoder;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       grant_rdy;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic [2:0] ptr;
`ifdef RR_GRANT_LOCK_EN
  logic       lock;
`endif

  int n_vec;
  int n_bad;

  logic [7:0] dec_out;
  logic [7:0] one8;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       vld;
    logic [2:0] idx;
    logic [2:0] ptr;
  } vec_t;

  vec_t tbl[$];

  rr_grant_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef RR_GRANT_LOCK_EN
    .lock      (lock),
`endif
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .grant_rdy (grant_rdy),
    .ptr       (ptr)
  );

  assign one8    = 8'h01;
  assign dec_out = one8 << grant_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic vld,
                         input logic [2:0] idx,
                         input logic [2:0] p);
    logic [7:0] oh;
    oh = 8'h01 << idx;
    chk({nm, ".vld"}, 32'(grant_vld), 32'(vld));
    chk({nm, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({nm, ".ptr"}, 32'(ptr), 32'(p));
    if (vld) chk({nm, ".dec"}, 32'(dec_out), 32'(oh));
  endtask

  task automatic step(input logic [7:0] r, input logic rd);
    req       = r;
    grant_rdy = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] r,
                              input logic rd, input logic v,
                              input logic [2:0] i,
                              input logic [2:0] p);
    vec_t t;
    t.req = r; t.rdy = rd; t.vld = v; t.idx = i; t.ptr = p;
    return t;
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req = 8'hFF;
    grant_rdy = 1'b0;
`ifdef RR_GRANT_LOCK_EN
    lock = 1'b0;
`endif

    // rotation 1..7,0 after first grant of 0
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(8'hFF, 1, 1, 3'(k), 3'(k)));
    // backpressure on index 2
    tbl.push_back(mk(8'h24, 1, 1, 3'd2, 3'd1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(8'h24, 0, 1, 3'd2, 3'd1));
    for (int k = 0; k < 2; k++)
      tbl.push_back(mk(8'h20, 0, 1, 3'd2, 3'd1));
    tbl.push_back(mk(8'h20, 1, 1, 3'd5, 3'd3));
    // wrap and sparse
    tbl.push_back(mk(8'h03, 1, 1, 3'd0, 3'd6));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 3'd1));
    tbl.push_back(mk(8'h00, 1, 0, 3'd0, 3'd1));
    tbl.push_back(mk(8'h01, 0, 1, 3'd0, 3'd1));
    tbl.push_back(mk(8'h80, 1, 1, 3'd7, 3'd1));
    tbl.push_back(mk(8'h80, 1, 1, 3'd7, 3'd0));
    tbl.push_back(mk(8'h81, 1, 1, 3'd0, 3'd0));

    // reset state with all requesting
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 3'd0, 3'd0);
    #3 rst_n = 1'b1;
    step(8'hFF, 1'b0);
    chk_all("first", 1'b1, 3'd0, 3'd0);

    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].rdy);
      chk_all($sformatf("vec%0d", i), tbl[i].vld,
              tbl[i].idx, tbl[i].ptr);
    end

    // async reset mid-grant
    step(8'hFF, 1'b1);
    chk_all("pre_rst", 1'b1, 3'd1, 3'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 3'd0, 3'd0);
    #1 rst_n = 1'b1;
    step(8'hFC, 1'b0);
    chk_all("restart", 1'b1, 3'd2, 3'd0);

`ifdef RR_GRANT_LOCK_EN
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step(8'h11, 1'b0);
    chk_all("lk_first", 1'b1, 3'd0, 3'd0);
    lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(8'h11, 1'b1);
      chk_all($sformatf("lk_hold%0d", k), 1'b1, 3'd0, 3'd0);
    end
    lock = 1'b0;
    step(8'h11, 1'b1);
    chk_all("lk_rel", 1'b1, 3'd4, 3'd1);
    lock = 1'b1;
    step(8'h01, 1'b1);
    chk_all("lk_noreq", 1'b1, 3'd0, 3'd5);
    lock = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
